// File: rtl/nv_fifo_ctrl_20x289.sv
// ---------------------------------------------------------------------------
// nv_fifo_ctrl_20x289
//
// Controls a 20-entry x 289-bit FIFO built on an external two-port RAM. The
// RAM has a registered read address (stage S1) and a registered data output
// (stage S2). This block tracks the pointers, occupancy and the two-stage
// read pipeline so that data comes out in write order with one entry per
// cycle of sustained throughput.
//
// Ports:
//   nvdla_core_clk         clock, all state updates on its rising edge
//   nvdla_core_rstn        asynchronous active-low reset
//   wr_pvld/wr_prdy/wr_pd  write handshake and payload (wr_prdy registered)
//   rd_pvld/rd_prdy/rd_pd  read handshake and payload (rd_pd = ram_dout)
//   ram_we/ram_wa/ram_di   RAM write port
//   ram_re/ram_ra          RAM read-address enable and address
//   ram_ore                RAM output-register enable
//   ram_dout               RAM registered output
//   pwrbus_ram_pd          power bus in, passed through to ram_pwrbus_pd
//   fifo_occ               registered occupancy, only present when the macro
//                          NV_FIFO_CTRL_20X289_OCC_EN is defined
// ---------------------------------------------------------------------------
module nv_fifo_ctrl_20x289 (
   input  logic         nvdla_core_clk,
   input  logic         nvdla_core_rstn,
   input  logic         wr_pvld,
   output logic         wr_prdy,
   input  logic [288:0] wr_pd,
   output logic         rd_pvld,
   input  logic         rd_prdy,
   output logic [288:0] rd_pd,
   output logic         ram_we,
   output logic [4:0]   ram_wa,
   output logic [288:0] ram_di,
   output logic         ram_re,
   output logic [4:0]   ram_ra,
   output logic         ram_ore,
   input  logic [288:0] ram_dout,
   input  logic [31:0]  pwrbus_ram_pd,
`ifdef NV_FIFO_CTRL_20X289_OCC_EN
   output logic [4:0]   fifo_occ,
`endif
   output logic [31:0]  ram_pwrbus_pd
);

   localparam logic [4:0] DEPTH    = 5'd20;
   localparam logic [4:0] LAST_IDX = 5'd19;

   // Pointer advance with wrap from the last entry back to zero.
   function automatic logic [4:0] ptr_inc(input logic [4:0] ptr);
      logic [4:0] nxt;
      if (ptr == LAST_IDX) begin
         nxt = 5'd0;
      end else begin
         nxt = ptr + 5'd1;
      end
      return nxt;
   endfunction

   logic [4:0] wr_ptr_q, wr_ptr_d;
   logic [4:0] rd_ptr_q, rd_ptr_d;
   logic [4:0] occ_q,    occ_d;
   logic [4:0] avail_q,  avail_d;
   logic       s1_vld_q, s1_vld_d;
   logic       s2_vld_q, s2_vld_d;
   logic       wr_prdy_q, wr_prdy_d;

   logic       wr_accept;
   logic       s1_adv;
   logic       rd_issue;
   logic       pop;

   // Handshake decode, read pipeline control and next-state computation.
   always_comb begin
      wr_accept = wr_pvld & wr_prdy_q;
      // S1 may hand its address to the output register when S2 is free or
      // is being drained this cycle.
      s1_adv    = s1_vld_q & (~s2_vld_q | rd_prdy);
      // Only fetch a new address when S1 is empty or moving on, otherwise
      // the RAM address register must hold the stalled entry.
      rd_issue  = (avail_q != 5'd0) & (~s1_vld_q | s1_adv);
      pop       = s2_vld_q & rd_prdy;

      if (wr_accept) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (rd_issue) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({wr_accept, pop})
         2'b10:   occ_d = occ_q + 5'd1;
         2'b01:   occ_d = occ_q - 5'd1;
         default: occ_d = occ_q;
      endcase

      case ({wr_accept, rd_issue})
         2'b10:   avail_d = avail_q + 5'd1;
         2'b01:   avail_d = avail_q - 5'd1;
         default: avail_d = avail_q;
      endcase

      // Occupancy includes entries still sitting in S1/S2, so a slot being
      // read can never be overwritten.
      wr_prdy_d = (occ_d < DEPTH);
      s1_vld_d  = rd_issue | (s1_vld_q & ~s1_adv);
      s2_vld_d  = s1_adv | (s2_vld_q & ~rd_prdy);
   end

   // Controller state registers.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         wr_ptr_q  <= 5'd0;
         rd_ptr_q  <= 5'd0;
         occ_q     <= 5'd0;
         avail_q   <= 5'd0;
         s1_vld_q  <= 1'b0;
         s2_vld_q  <= 1'b0;
         wr_prdy_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         occ_q     <= occ_d;
         avail_q   <= avail_d;
         s1_vld_q  <= s1_vld_d;
         s2_vld_q  <= s2_vld_d;
         wr_prdy_q <= wr_prdy_d;
      end
   end

   // Output drive: RAM ports, read side and power-bus pass-through.
   always_comb begin
      wr_prdy       = wr_prdy_q;
      ram_we        = wr_accept;
      ram_wa        = wr_ptr_q;
      ram_di        = wr_pd;
      ram_re        = rd_issue;
      ram_ra        = rd_ptr_q;
      ram_ore       = s1_adv;
      rd_pvld       = s2_vld_q;
      rd_pd         = ram_dout;
      ram_pwrbus_pd = pwrbus_ram_pd;
   end

`ifdef NV_FIFO_CTRL_20X289_OCC_EN
   assign fifo_occ = occ_q;
`endif

endmodule

// File: doc/nv_fifo_ctrl_20x289.md
NV_FIFO_CTRL_20X289 -- requirements
Module: nv_fifo_ctrl_20x289

Interface
REQ-001 Parameters SHALL be none; depth (20 entries) and width (289 bits) are fixed.
REQ-002 nvdla_core_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 nvdla_core_rstn  input  1  reset, asynchronous, active-low.
REQ-004 wr_pvld  input  1  write-side valid.
REQ-005 wr_prdy  output  1  write-side ready, registered.
REQ-006 wr_pd  input  289  write payload.
REQ-007 rd_pvld  output  1  read-side valid.
REQ-008 rd_prdy  input  1  read-side ready.
REQ-009 rd_pd  output  289  read payload, driven directly from ram_dout.
REQ-010 ram_we / ram_wa / ram_di  output  1/5/289  RAM write port.
REQ-011 ram_re / ram_ra  output  1/5  RAM read-address enable and address.
REQ-012 ram_ore  output  1  RAM output-register enable.
REQ-013 ram_dout  input  289  RAM registered output (valid one cycle after ram_ore).
REQ-014 pwrbus_ram_pd  input  32  power bus; ram_pwrbus_pd  output  32  combinational pass-through.

Function
REQ-015 Write accept SHALL be wr_pvld & wr_prdy; in that cycle ram_we=1, ram_wa=wr_ptr, ram_di=wr_pd (combinational); otherwise ram_we=0.
REQ-016 wr_ptr and rd_ptr SHALL be 5-bit, incrementing 0..19 and wrapping 19->0.
REQ-017 occ (0..20) SHALL count entries written and not yet popped: +1 on write accept, -1 on pop, unchanged when both occur in one cycle.
REQ-018 wr_prdy SHALL register (occ_next < 20); at occ=20 no write is accepted.
REQ-019 avail (0..20) SHALL count entries written and not yet issued to the RAM: +1 on write accept, -1 on ram_re, unchanged when both occur.
REQ-020 Read pipeline SHALL have stage S1 (address latched in RAM) and stage S2 (data in RAM output register), flags s1_vld and s2_vld.
REQ-021 s1_adv = s1_vld & (!s2_vld | rd_prdy); ram_ore = s1_adv.
REQ-022 ram_re = (avail != 0) & (!s1_vld | s1_adv); ram_ra = rd_ptr; rd_ptr increments on ram_re.
REQ-023 s1_vld_next = ram_re | (s1_vld & !s1_adv); s2_vld_next = s1_adv | (s2_vld & !rd_prdy).
REQ-024 rd_pvld = s2_vld; pop = s2_vld & rd_prdy.
REQ-025 While S1 or S2 is stalled, ram_re/ram_ore SHALL be 0 so RAM address and output registers hold; the held entry SHALL NOT be overwritten (guaranteed by REQ-017/018).
REQ-026 Latency: write accepted in cycle T SHALL give rd_pvld=1 in cycle T+3 when pipeline empty; sustained throughput one entry per cycle with rd_prdy=1.
REQ-027 Data SHALL be delivered in write order, with no loss or duplication across wrap-around.
REQ-028 Empty (avail=0): ram_re=0; a write in the same cycle is not issued before the next cycle.

Reset
REQ-029 On nvdla_core_rstn=0 (asynchronous): wr_ptr=0, rd_ptr=0, occ=0, avail=0, s1_vld=0, s2_vld=0, wr_prdy=0.
REQ-030 After reset: ram_we=ram_re=ram_ore=0, rd_pvld=0; wr_prdy=1 on the first rising edge after release.
REQ-031 Reset mid-operation SHALL discard all contents; RAM contents are not cleared and are never read without a fresh write.

Configuration
REQ-032 Macro NV_FIFO_CTRL_20X289_OCC_EN defined: output port fifo_occ [4:0] = occ (registered), reset 0.
REQ-033 Macro undefined: port fifo_occ absent; all other behaviour identical.

Verification
REQ-034 Single write 0x1_2345 at cycle T, rd_prdy=1 -> rd_pvld=1, rd_pd=0x1_2345 at T+3 only; occ returns 0.
REQ-035 20 writes with rd_prdy=0 -> wr_prdy=0 after 20th accept; 21st payload not accepted; fifo_occ=20.
REQ-036 From full, rd_prdy=1 for one cycle -> one pop, wr_prdy=1 next cycle; new write lands at wa=0 after wrap.
REQ-037 Continuous write and read of 100 incrementing values with random rd_prdy stalls -> output sequence 0..99 in order, no duplicates, ram_re/ram_ore never asserted while stage stalled.
REQ-038 Assert nvdla_core_rstn=0 with 7 entries queued and s2_vld=1 -> rd_pvld=0, wr_prdy=0 immediately; after release, fifo_occ=0 and first written value is first read.
